// File: rtl/block_loader.sv
// Byte-to-block assembler: packs BLOCK_WIDTH/8 bytes MSB-first from a valid/ready
// byte stream, then holds the finished block behind a valid/ready handshake.
module block_loader #(
    parameter  int BLOCK_WIDTH = 64,
    localparam int N           = BLOCK_WIDTH / 8,
    localparam int CW          = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic [BLOCK_WIDTH-1:0] block_out,
    output logic                   block_valid,
    input  logic                   block_ready,
    output logic [CW-1:0]          byte_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [BLOCK_WIDTH-1:0] blk_buf;
    logic [BLOCK_WIDTH-1:0] blk_buf_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            blk_buf <= '0;
            count   <= '0;
        end else begin
            state   <= state_next;
            blk_buf <= blk_buf_next;
            count   <= count_next;
        end
    end

    // The old block is never zeroed on handshake; the next N bytes shift it out.
    always_comb begin
        state_next   = state;
        blk_buf_next = blk_buf;
        count_next   = count;
        if (clear) begin
            state_next   = FILL;
            blk_buf_next = '0;
            count_next   = '0;
        end else begin
            case (state)
                FILL: begin
                    if (byte_valid) begin
                        blk_buf_next = {blk_buf[BLOCK_WIDTH-9:0], byte_in};
                        if (count == CW'(N - 1)) begin
                            count_next = '0;
                            state_next = HOLD;
                        end else begin
                            count_next = count + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (block_ready) begin
                        state_next = FILL;
                    end
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

    // Handshake flags come only from registered state, never from inputs.
    assign byte_ready  = (state == FILL);
    assign block_valid = (state == HOLD);
    assign block_out   = blk_buf;
    assign byte_count  = count;

endmodule
